// File: rtl/sound_scheduler.sv
// Sound request scheduler: latches one-cycle requests, arbitrates by fixed
// priority and drives one play command at a time into the shared player.
module sound_scheduler #(
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter int unsigned ACK_TIMEOUT = 5000,
  parameter logic [31:0] MAX_PLAY    = 32'd1500000000,
  parameter bit          PREEMPT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] req,
  input  logic       player_busy,
  output logic       play_start,
  output logic [3:0] play_id,
  output logic       player_abort,
  output logic       active,
  output logic       err_timeout,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAIT_ACK, PLAYING, ABORT, GAP
  } state_t;

  localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] PLAY_LAST = MAX_PLAY - 32'd1;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [8:0]  pending, launch;
  logic [3:0]  sel, id_nxt;
  logic        start_nxt, abort_nxt, err_nxt;
  logic [3:0]  drops;
  logic [8:0]  drop_sum;

  // Fixed priority: round-end, opening, gun, songs fast..slow, walk, spare
  always_comb begin
    sel = 4'd0;
    priority case (1'b1)
      pending[8]: sel = 4'd8;
      pending[7]: sel = 4'd7;
      pending[4]: sel = 4'd4;
      pending[3]: sel = 4'd3;
      pending[2]: sel = 4'd2;
      pending[1]: sel = 4'd1;
      pending[0]: sel = 4'd0;
      pending[5]: sel = 4'd5;
      pending[6]: sel = 4'd6;
      default:    sel = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 32'd1;
    id_nxt    = play_id;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;
    launch    = '0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|pending) begin
          start_nxt = 1'b1;
          id_nxt    = sel;
          launch    = 9'd1 << sel;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (player_busy) begin
          state_nxt = PLAYING;
          cnt_nxt   = '0;
        end else if (cnt == ACK_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      PLAYING: begin
        if (!player_busy) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (PREEMPT && pending[4] && play_id != 4'd4) begin
          abort_nxt = 1'b1;
          state_nxt = ABORT;
          cnt_nxt   = '0;
        end else if (cnt == PLAY_LAST) begin
          abort_nxt = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = ABORT;
          cnt_nxt   = '0;
        end
      end
      ABORT: begin
        if (!player_busy) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == ACK_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A request landing on the launch cycle re-arms the bit, not a drop
  always_comb begin
    drops = '0;
    for (int i = 0; i < 9; i++) begin
      drops = drops + 4'(req[i] & pending[i] & ~launch[i]);
    end
    drop_sum = {1'b0, drop_cnt} + {5'd0, drops};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending      <= '0;
      play_start   <= 1'b0;
      play_id      <= '0;
      player_abort <= 1'b0;
      err_timeout  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pending      <= (pending & ~launch) | req;
      play_start   <= start_nxt;
      play_id      <= id_nxt;
      player_abort <= abort_nxt;
      err_timeout  <= err_nxt;
      drop_cnt     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: scripted player, timestamp-based reference
// model compared every cycle, plus directed scenario expectations.
module tb_sound_scheduler;

  localparam int GAP  = 8;
  localparam int ACK  = 16;
  localparam int MAXP = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       player_busy = 1'b0;
  logic [8:0] req = '0;
  logic       play_start, player_abort, active, err_timeout;
  logic [3:0] play_id;
  logic [7:0] drop_cnt;

  sound_scheduler #(
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK),
    .MAX_PLAY(32'(MAXP)), .PREEMPT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .player_busy(player_busy),
    .play_start(play_start), .play_id(play_id),
    .player_abort(player_abort), .active(active),
    .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic timed_out(string nm);
    total++;
    $display("FAIL %s: wait budget expired", nm);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phases with entry timestamps
  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2;
  localparam int P_ABORT = 3, P_GAP = 4;
  int         prio [9] = '{8, 7, 4, 3, 2, 1, 0, 5, 6};
  int         m_ph = P_IDLE, t_in = 0, m_id = 0, m_drop = 0;
  logic [8:0] m_pend = '0;
  logic       e_start = 1'b0, e_abort = 1'b0, e_err = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int el, nph;
    logic [8:0] gone;
    if (rst) begin
      m_ph = P_IDLE; m_pend = '0; m_id = 0; m_drop = 0;
      e_start = 1'b0; e_abort = 1'b0; e_err = 1'b0;
    end else begin
      el = cyc - t_in;
      nph = m_ph;
      gone = '0;
      e_start = 1'b0; e_abort = 1'b0; e_err = 1'b0;
      case (m_ph)
        P_IDLE: if (m_pend != '0) begin
          for (int k = 8; k >= 0; k--)
            if (m_pend[prio[k]]) m_id = prio[k];
          gone[m_id] = 1'b1;
          e_start = 1'b1;
          nph = P_WAIT;
        end
        P_WAIT: begin
          if (player_busy) nph = P_PLAY;
          else if (el == ACK - 1) begin e_err = 1'b1; nph = P_GAP; end
        end
        P_PLAY: begin
          if (!player_busy) nph = P_GAP;
          else if (m_pend[4] && m_id != 4) begin
            e_abort = 1'b1; nph = P_ABORT;
          end else if (el == MAXP - 1) begin
            e_abort = 1'b1; e_err = 1'b1; nph = P_ABORT;
          end
        end
        P_ABORT: begin
          if (!player_busy) nph = P_GAP;
          else if (el == ACK - 1) begin e_err = 1'b1; nph = P_GAP; end
        end
        default: if (el == GAP - 1) nph = P_IDLE;
      endcase
      for (int i = 0; i < 9; i++) begin
        if (req[i]) begin
          if (m_pend[i] && !gone[i] && m_drop < 255) m_drop++;
          m_pend[i] = 1'b1;
        end else if (gone[i]) m_pend[i] = 1'b0;
      end
      if (nph != m_ph) t_in = cyc + 1;
      m_ph = nph;
    end
  end

  // Scripted player: ack after ack_dly cycles (0 = never), play play_len
  int ack_dly = 3, play_len = 100, dly = -1, left = 0;
  always @(posedge clk) begin : player
    logic ps, pa;
    ps = play_start;
    pa = player_abort;
    #1;
    if (rst || pa) begin
      player_busy = 1'b0; dly = -1; left = 0;
    end else if (player_busy) begin
      left--;
      if (left <= 0) player_busy = 1'b0;
    end else begin
      if (ps && ack_dly > 0) dly = ack_dly;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          player_busy = 1'b1; left = play_len; dly = -1;
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  int st_id[$], st_cyc[$], err_q[$], ab_q[$];
  int act_cnt = 0;

  always @(negedge clk) if (cmp_en) begin
    chk("play_start", int'(play_start), int'(e_start));
    chk("play_id", int'(play_id), m_id);
    chk("player_abort", int'(player_abort), int'(e_abort));
    chk("err_timeout", int'(err_timeout), int'(e_err));
    chk("active", int'(active), int'(m_ph != P_IDLE));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    if (play_start) begin st_id.push_back(int'(play_id)); st_cyc.push_back(cyc); end
    if (err_timeout) err_q.push_back(cyc);
    if (player_abort) ab_q.push_back(cyc);
    if (active) act_cnt++;
  end

  function automatic int id_at(int i);
    return (i < st_id.size()) ? st_id[i] : -1;
  endfunction
  function automatic int scyc(int i);
    return (i < st_cyc.size()) ? st_cyc[i] : -1000;
  endfunction
  function automatic int ecyc(int i);
    return (i < err_q.size()) ? err_q[i] : -1000;
  endfunction
  function automatic int acyc(int i);
    return (i < ab_q.size()) ? ab_q[i] : -1000;
  endfunction

  int pulse_cyc = 0;
  task automatic pulse(logic [8:0] v);
    @(posedge clk); #1;
    req = v;
    pulse_cyc = cyc;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic wait_quiet(string nm, int budget);
    int n = 0;
    while (!(m_ph == P_IDLE && m_pend == '0 && !active)) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin timed_out(nm); return; end
    end
  endtask

  task automatic wait_busy(string nm, int budget);
    int n = 0;
    while (!player_busy) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin timed_out(nm); return; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int b0, e0, a0, pc, n5;
  bit ok;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_play_start", int'(play_start), 0);
    chk("rst_play_id", int'(play_id), 0);
    chk("rst_abort", int'(player_abort), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // single slow song
    ack_dly = 3; play_len = 100;
    b0 = st_id.size(); e0 = err_q.size(); act_cnt = 0;
    pulse(9'h001);
    wait_quiet("s1_quiet", 400);
    chk("s1_starts", st_id.size() - b0, 1);
    chk("s1_id", id_at(b0), 0);
    chk("s1_active_cycles", act_cnt, 3 + 100 + 1 + GAP);
    chk("s1_errs", err_q.size() - e0, 0);

    // four simultaneous requests
    ack_dly = 2; play_len = 20;
    b0 = st_id.size();
    pulse(9'h131);
    wait_quiet("s2_quiet", 600);
    chk("s2_starts", st_id.size() - b0, 4);
    chk("s2_id0", id_at(b0), 8);
    chk("s2_id1", id_at(b0 + 1), 4);
    chk("s2_id2", id_at(b0 + 2), 0);
    chk("s2_id3", id_at(b0 + 3), 5);
    ok = 1'b1;
    for (int i = 1; i < 4; i++)
      if (scyc(b0 + i) - scyc(b0 + i - 1) < GAP) ok = 1'b0;
    chk("s2_spacing", int'(ok), 1);
    chk("s2_drop", int'(drop_cnt), 0);

    // gun preempts song 2
    ack_dly = 3; play_len = 500;
    b0 = st_id.size(); e0 = err_q.size(); a0 = ab_q.size();
    pulse(9'h004);
    wait_busy("s3_busy", 50);
    repeat (10) @(posedge clk);
    #1;
    play_len = 20;
    pulse(9'h010);
    pc = pulse_cyc;
    wait_quiet("s3_quiet", 400);
    chk("s3_abort_lat", acyc(a0) - pc, 2);
    chk("s3_starts", st_id.size() - b0, 2);
    chk("s3_id0", id_at(b0), 2);
    chk("s3_id1", id_at(b0 + 1), 4);
    chk("s3_errs", err_q.size() - e0, 0);

    // player never acknowledges
    ack_dly = 0;
    b0 = st_id.size(); e0 = err_q.size();
    pulse(9'h00A);
    begin
      int n = 0;
      while (err_q.size() == e0 && n <= 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (err_q.size() == e0) timed_out("s4_err_wait");
    end
    ack_dly = 2; play_len = 10;
    wait_quiet("s4_quiet", 300);
    chk("s4_ack_timeout", ecyc(e0) - scyc(b0), ACK);
    chk("s4_id0", id_at(b0), 3);
    chk("s4_id1", id_at(b0 + 1), 1);
    chk("s4_restart", scyc(b0 + 1) - ecyc(e0), GAP + 1);
    chk("s4_errs", err_q.size() - e0, 1);

    // walk coalescing, then drop saturation
    ack_dly = 3; play_len = 60;
    b0 = st_id.size();
    pulse(9'h001);
    wait_busy("s5_busy", 50);
    repeat (5) pulse(9'h020);
    chk("s5_drop4", int'(drop_cnt), 4);
    wait_quiet("s5_quiet", 400);
    n5 = 0;
    for (int i = b0; i < st_id.size(); i++) if (st_id[i] == 5) n5++;
    chk("s5_walk_once", n5, 1);
    ack_dly = 2; play_len = 20;
    @(posedge clk); #1;
    req = 9'h020;
    repeat (300) @(posedge clk);
    #1;
    req = '0;
    wait_quiet("s5_sat_quiet", 400);
    chk("s5_drop_sat", int'(drop_cnt), 255);

    // stuck-busy song hits MAX_PLAY
    ack_dly = 3; play_len = 300;
    b0 = st_id.size(); e0 = err_q.size(); a0 = ab_q.size();
    pulse(9'h002);
    wait_quiet("s7_quiet", 800);
    chk("s7_aborts", ab_q.size() - a0, 1);
    chk("s7_errs", err_q.size() - e0, 1);
    chk("s7_abort_at", acyc(a0) - scyc(b0), 4 + MAXP);
    chk("s7_err_at", ecyc(e0) - scyc(b0), 4 + MAXP);

    // asynchronous reset mid-song with pending bits
    ack_dly = 3; play_len = 150;
    pulse(9'h001);
    wait_busy("s6_busy", 50);
    pulse(9'h0C0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("s6_play_start", int'(play_start), 0);
    chk("s6_play_id", int'(play_id), 0);
    chk("s6_abort", int'(player_abort), 0);
    chk("s6_active", int'(active), 0);
    chk("s6_err", int'(err_timeout), 0);
    chk("s6_drop", int'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b0 = st_id.size();
    repeat (50) @(posedge clk);
    #1;
    chk("s6_no_start", st_id.size() - b0, 0);
    chk("s6_idle", int'(active), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
